// File: rtl/cfg_write_arb.sv
// Write arbiter for the configuration register bank: buffers SPI writes in a
// 2-entry FIFO and round-robins them with sequencer writes, one at a time.
module cfg_write_arb #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_data,
   input  logic              spi_update,
   input  logic [ADDR_W-1:0] seq_addr,
   input  logic [DATA_W-1:0] seq_data,
   input  logic              seq_valid,
   output logic              seq_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   input  logic              wr_ack,
   input  logic              ovf_clear,
   output logic              spi_overflow,
   output logic              busy
);

   // state    | meaning
   // ST_IDLE  | no write outstanding; grant a pending source and load wr_*
   // ST_WRITE | wr_en high, wr_* held until the bank acks
   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   localparam int ENTRY_W = ADDR_W + DATA_W;

   state_t             state;
   logic [ENTRY_W-1:0] fifo_mem [2];
   logic               rd_ptr;
   logic               wr_ptr;
   logic [1:0]         count;
   logic               last_grant_spi;

   logic               spi_req;
   logic               grant_spi;
   logic               grant_seq;
   logic               pop;
   logic               push;
   logic               drop;
   logic [ENTRY_W-1:0] fifo_head;

   assign fifo_head = fifo_mem[rd_ptr];
   assign spi_req   = (count != 2'd0);
   assign grant_spi = spi_req && (!seq_valid || !last_grant_spi);
   assign grant_seq = seq_valid && (!spi_req || last_grant_spi);
   assign pop       = (state == ST_IDLE) && grant_spi;
   // A full FIFO still accepts a push when its head leaves in the same cycle.
   assign push      = spi_update && ((count != 2'd2) || pop);
   assign drop      = spi_update && (count == 2'd2) && !pop;

   assign seq_ready = (state == ST_IDLE) && grant_seq;
   assign busy      = (state == ST_WRITE) || (count != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         rd_ptr         <= 1'b0;
         wr_ptr         <= 1'b0;
         count          <= 2'd0;
         last_grant_spi <= 1'b0;
         spi_overflow   <= 1'b0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {spi_addr, spi_data};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);

         if (drop) begin
            spi_overflow <= 1'b1;
         end else if (ovf_clear) begin
            spi_overflow <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (grant_spi) begin
                  wr_addr        <= fifo_head[ENTRY_W-1:DATA_W];
                  wr_data        <= fifo_head[DATA_W-1:0];
                  last_grant_spi <= 1'b1;
                  wr_en          <= 1'b1;
                  state          <= ST_WRITE;
               end else if (grant_seq) begin
                  wr_addr        <= seq_addr;
                  wr_data        <= seq_data;
                  last_grant_spi <= 1'b0;
                  wr_en          <= 1'b1;
                  state          <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (wr_ack) begin
                  wr_en <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               wr_en <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_write_arb.sv
// Directed bench for cfg_write_arb: a vector table for the basic SPI/sequencer
// flow, then hand-written sequences for overflow, full push+pop, stall and reset.
module tb_cfg_write_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] spi_addr, spi_data, seq_addr, seq_data;
   logic       spi_update, seq_valid, seq_ready;
   logic [7:0] wr_addr, wr_data;
   logic       wr_en, wr_ack, ovf_clear, spi_overflow, busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cfg_write_arb #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .spi_addr(spi_addr), .spi_data(spi_data), .spi_update(spi_update),
      .seq_addr(seq_addr), .seq_data(seq_data), .seq_valid(seq_valid),
      .seq_ready(seq_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_ack(wr_ack),
      .ovf_clear(ovf_clear), .spi_overflow(spi_overflow), .busy(busy)
   );

   typedef struct packed {
      logic       spi_update;
      logic [7:0] spi_addr;
      logic [7:0] spi_data;
      logic       seq_valid;
      logic [7:0] seq_addr;
      logic [7:0] seq_data;
      logic       wr_ack;
      logic       e_wr_en;
      logic [7:0] e_addr;
      logic [7:0] e_data;
      logic       e_ready;
      logic       e_busy;
      logic       e_ovf;
   } vec_t;

   vec_t vecs [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      spi_update = 1'b0; spi_addr = '0; spi_data = '0;
      seq_valid  = 1'b0; seq_addr = '0; seq_data = '0;
      wr_ack     = 1'b0; ovf_clear = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic pulse_spi(input logic [7:0] a, input logic [7:0] d);
      spi_update = 1'b1; spi_addr = a; spi_data = d;
      step();
      spi_update = 1'b0; spi_addr = 8'hxx; spi_data = 8'hxx;
   endtask

   task automatic wait_wr(input string name, input int budget);
      int i = 0;
      while (wr_en !== 1'b1 && i < budget) begin
         step();
         i++;
      end
      chk({name, " wr_en"}, {15'd0, wr_en}, 16'd1);
   endtask

   task automatic ack_write(input string name);
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      chk({name, " wr_en low after ack"}, {15'd0, wr_en}, 16'd0);
   endtask

   task automatic expect_write(input string name, input logic [7:0] a, input logic [7:0] d);
      wait_wr(name, 8);
      chk({name, " addr"}, {8'd0, wr_addr}, {8'd0, a});
      chk({name, " data"}, {8'd0, wr_data}, {8'd0, d});
      ack_write(name);
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (wr_en === 1'b1) seen = 1'b1;
         step();
      end
      chk({name, " no further write"}, {15'd0, seen}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // spi_upd a d | seq_v a d | ack | wr_en addr data | ready busy ovf
      vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h01, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 8'h22, 1'b1, 1'b1, 8'h01, 8'h11, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 8'h22, 1'b0, 1'b0, 8'h01, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h02, 8'h22, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'h22, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h22, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12, 8'hA5, 1'b0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         spi_update = vecs[i].spi_update;
         spi_addr   = vecs[i].spi_addr;
         spi_data   = vecs[i].spi_data;
         seq_valid  = vecs[i].seq_valid;
         seq_addr   = vecs[i].seq_addr;
         seq_data   = vecs[i].seq_data;
         wr_ack     = vecs[i].wr_ack;
         #1;
         chk($sformatf("vec%0d wr_en", i),        {15'd0, wr_en},        {15'd0, vecs[i].e_wr_en});
         chk($sformatf("vec%0d wr_addr", i),      {8'd0, wr_addr},       {8'd0, vecs[i].e_addr});
         chk($sformatf("vec%0d wr_data", i),      {8'd0, wr_data},       {8'd0, vecs[i].e_data});
         chk($sformatf("vec%0d seq_ready", i),    {15'd0, seq_ready},    {15'd0, vecs[i].e_ready});
         chk($sformatf("vec%0d busy", i),         {15'd0, busy},         {15'd0, vecs[i].e_busy});
         chk($sformatf("vec%0d spi_overflow", i), {15'd0, spi_overflow}, {15'd0, vecs[i].e_ovf});
         step();
      end
      spi_update = 1'b0; seq_valid = 1'b0; wr_ack = 1'b0;

      // Overflow: ack held low, fourth pulse lands on a full FIFO.
      do_reset();
      pulse_spi(8'h30, 8'h31);
      pulse_spi(8'h32, 8'h33);
      pulse_spi(8'h34, 8'h35);
      chk("ovf pre flag", {15'd0, spi_overflow}, 16'd0);
      pulse_spi(8'h36, 8'h37);
      chk("ovf flag set", {15'd0, spi_overflow}, 16'd1);
      chk("ovf first on bus", {8'd0, wr_addr}, 16'h0030);
      expect_write("ovf w1", 8'h30, 8'h31);
      expect_write("ovf w2", 8'h32, 8'h33);
      expect_write("ovf w3", 8'h34, 8'h35);
      expect_quiet("ovf dropped", 6);
      chk("ovf busy drained", {15'd0, busy}, 16'd0);
      chk("ovf sticky", {15'd0, spi_overflow}, 16'd1);
      ovf_clear = 1'b1;
      step();
      ovf_clear = 1'b0;
      chk("ovf cleared", {15'd0, spi_overflow}, 16'd0);

      // Push and pop in the same cycle with the FIFO full.
      do_reset();
      pulse_spi(8'h40, 8'h41);
      pulse_spi(8'h42, 8'h43);
      pulse_spi(8'h44, 8'h45);
      chk("pp first addr", {8'd0, wr_addr}, 16'h0040);
      ack_write("pp w1");
      pulse_spi(8'h46, 8'h47);
      chk("pp no overflow", {15'd0, spi_overflow}, 16'd0);
      expect_write("pp w2", 8'h42, 8'h43);
      expect_write("pp w3", 8'h44, 8'h45);
      expect_write("pp w4", 8'h46, 8'h47);
      chk("pp overflow end", {15'd0, spi_overflow}, 16'd0);

      // Long ack latency with the sequencer waiting.
      do_reset();
      pulse_spi(8'h50, 8'h51);
      wait_wr("hold start", 4);
      seq_valid = 1'b1; seq_addr = 8'h60; seq_data = 8'h61;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold%0d wr_en", i),     {15'd0, wr_en},     16'd1);
         chk($sformatf("hold%0d wr_addr", i),   {8'd0, wr_addr},    16'h0050);
         chk($sformatf("hold%0d wr_data", i),   {8'd0, wr_data},    16'h0051);
         chk($sformatf("hold%0d seq_ready", i), {15'd0, seq_ready}, 16'd0);
         step();
      end
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      chk("hold seq_ready after ack", {15'd0, seq_ready}, 16'd1);
      step();
      seq_valid = 1'b0;
      chk("hold seq_ready in write", {15'd0, seq_ready}, 16'd0);
      expect_write("hold seq write", 8'h60, 8'h61);

      // Reset mid-write with a full FIFO and overflow set.
      do_reset();
      pulse_spi(8'h70, 8'h71);
      pulse_spi(8'h72, 8'h73);
      pulse_spi(8'h74, 8'h75);
      pulse_spi(8'h76, 8'h77);
      chk("rst pre wr_en", {15'd0, wr_en}, 16'd1);
      chk("rst pre ovf", {15'd0, spi_overflow}, 16'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst wr_en", {15'd0, wr_en}, 16'd0);
      chk("rst busy", {15'd0, busy}, 16'd0);
      chk("rst ovf", {15'd0, spi_overflow}, 16'd0);
      chk("rst wr_addr", {8'd0, wr_addr}, 16'd0);
      expect_quiet("rst flushed", 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
